// File: rtl/edge_pulse_gen_pkg.sv
// Shared encodings for the debounced edge/pulse generator: FSM states, mode codes
// and the edge-enable decision.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  function automatic logic edge_enabled(input logic [1:0] mode, input logic rising);
    logic en;
    case (mode)
      MODE_RISE: en = rising;
      MODE_FALL: en = ~rising;
      MODE_BOTH: en = 1'b1;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_pulse_gen_if.sv
// Channel-vector bus between the edge_pulse_gen block and its controller.
// The master drives raw inputs and configuration; the slave returns pulses and status.
interface edge_pulse_gen_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]   in;
  logic [2*N_CH-1:0] mode;
  logic [CNT_W-1:0]  deb_len;
  logic [CNT_W-1:0]  holdoff;
  logic [N_CH-1:0]   dato;
  logic [N_CH-1:0]   edge_dir;
  logic [N_CH-1:0]   lvl;
  logic [N_CH-1:0]   busy;

  modport master (
    output in, mode, deb_len, holdoff,
    input  dato, edge_dir, lvl, busy
  );

  modport slave (
    input  in, mode, deb_len, holdoff,
    output dato, edge_dir, lvl, busy
  );
endinterface

// File: rtl/edge_pulse_gen_ch.sv
// One channel: input synchroniser, debounce qualifier, one-shot pulse and holdoff.
// All outputs are registered from a single next-state computation.
module edge_pulse_ch
  import edge_pulse_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkm,
  input  logic             reset_n,
  input  logic             i_in,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_deb_len,
  input  logic [CNT_W-1:0] i_holdoff,
  output logic             o_dato,
  output logic             o_edge_dir,
  output logic             o_lvl,
  output logic             o_busy
);

  logic w_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = i_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      // Synchroniser shift chain, bit 0 nearest the pin
      always_ff @(posedge clkm) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= i_in;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_lvl, w_lvl_nxt;
  logic             r_dato, w_dato_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_busy;
  logic             w_accept;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_qual_done, w_hold_done, w_deb_short;

  // Limits are compared live, so lowering them mid-flight ends QUAL/HOLD at once
  assign w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_qual_done = (w_cnt_inc >= {1'b0, i_deb_len});
  assign w_hold_done = (w_cnt_inc >= {1'b0, i_holdoff});
  assign w_deb_short = (i_deb_len <= CNT_W'(1));

  // Next-state, counter, level and pulse decision
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lvl_nxt   = r_lvl;
    w_dato_nxt  = 1'b0;
    w_dir_nxt   = 1'b0;
    w_accept    = 1'b0;
    if (i_mode == MODE_OFF) begin
      // Tracking the level while disabled prevents a stale pulse on re-enable
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_lvl_nxt   = w_s;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s == r_lvl) begin
            w_cnt_nxt = '0;
          end else if (w_deb_short) begin
            w_accept = 1'b1;
          end else begin
            w_state_nxt = QUAL;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        QUAL: begin
          if (w_s == r_lvl) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (w_qual_done) begin
            w_accept = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          end
        end
        HOLD: begin
          if (w_hold_done) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
      if (w_accept) begin
        w_lvl_nxt   = w_s;
        w_dato_nxt  = edge_enabled(i_mode, w_s);
        w_dir_nxt   = edge_enabled(i_mode, w_s) & w_s;
        w_cnt_nxt   = '0;
        w_state_nxt = (i_holdoff != '0) ? HOLD : IDLE;
      end else begin
        w_dato_nxt = 1'b0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clkm) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_dato  <= 1'b0;
      r_dir   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lvl   <= w_lvl_nxt;
      r_dato  <= w_dato_nxt;
      r_dir   <= w_dir_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign o_dato     = r_dato;
  assign o_edge_dir = r_dir;
  assign o_lvl      = r_lvl;
  assign o_busy     = r_busy;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel debounced edge detector / one-shot generator feeding DPWM strobes.
// Channels are independent; debounce length and holdoff are shared.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic              clkm,
  input logic              reset_n,
  edge_pulse_gen_if.slave  bus
);

  logic [N_CH-1:0] w_dato, w_dir, w_lvl, w_busy;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      edge_pulse_ch #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
      ) u_ch (
        .clkm       (clkm),
        .reset_n    (reset_n),
        .i_in       (bus.in[c]),
        .i_mode     (bus.mode[2*c +: 2]),
        .i_deb_len  (bus.deb_len),
        .i_holdoff  (bus.holdoff),
        .o_dato     (w_dato[c]),
        .o_edge_dir (w_dir[c]),
        .o_lvl      (w_lvl[c]),
        .o_busy     (w_busy[c])
      );
    end
  endgenerate

  assign bus.dato     = w_dato;
  assign bus.edge_dir = w_dir;
  assign bus.lvl      = w_lvl;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Randomised and directed bench for edge_pulse_gen against a behavioural
// per-channel model (disagreement run length + holdoff age).
module tb_edge_pulse_gen;
  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;

  logic clkm = 1'b0;
  logic rst_n = 1'b0;
  always #5 clkm = ~clkm;

  edge_pulse_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  edge_pulse_gen #(.N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
    .clkm    (clkm),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // model state
  logic [SYNC-1:0] sp [N_CH];
  logic [N_CH-1:0] m_lvl, m_dato, m_dir, m_busy;
  int run_len [N_CH];
  int hage [N_CH];

  // observation counters
  int pc [N_CH];
  int bc [N_CH];
  int coinc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_step();
    logic s;
    logic en;
    int eff_deb;
    int hold;
    logic [1:0] md;
    eff_deb = (bus.deb_len == '0) ? 1 : int'(bus.deb_len);
    hold = int'(bus.holdoff);
    for (int c = 0; c < N_CH; c++) begin
      md = bus.mode[2*c +: 2];
      s = sp[c][SYNC-1];
      m_dato[c] = 1'b0;
      m_dir[c] = 1'b0;
      if (!rst_n) begin
        sp[c] = '0;
        m_lvl[c] = 1'b0;
        run_len[c] = 0;
        hage[c] = -1;
      end else begin
        for (int k = SYNC-1; k > 0; k--) sp[c][k] = sp[c][k-1];
        sp[c][0] = bus.in[c];
        if (md == 2'b11) begin
          m_lvl[c] = s;
          run_len[c] = 0;
          hage[c] = -1;
        end else if (hage[c] >= 0) begin
          if (hage[c] + 1 >= hold) hage[c] = -1;
          else hage[c] = hage[c] + 1;
        end else if (s == m_lvl[c]) begin
          run_len[c] = 0;
        end else begin
          run_len[c] = run_len[c] + 1;
          if (run_len[c] >= eff_deb) begin
            m_lvl[c] = s;
            run_len[c] = 0;
            en = (md == 2'b10) || (md == 2'b00 && s) || (md == 2'b01 && !s);
            m_dato[c] = en;
            m_dir[c] = en & s;
            hage[c] = (hold > 0) ? 0 : -1;
          end
        end
      end
      m_busy[c] = (run_len[c] > 0) || (hage[c] >= 0);
    end
  endtask

  task automatic step();
    @(posedge clkm);
    model_step();
    #1;
    check("dato", 32'(bus.dato), 32'(m_dato));
    check("edge_dir", 32'(bus.edge_dir), 32'(m_dir));
    check("lvl", 32'(bus.lvl), 32'(m_lvl));
    check("busy", 32'(bus.busy), 32'(m_busy));
    for (int c = 0; c < N_CH; c++) begin
      if (bus.dato[c]) pc[c]++;
      if (bus.busy[c]) bc[c]++;
    end
    if (bus.dato == 4'hF) coinc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr_counts();
    for (int c = 0; c < N_CH; c++) begin
      pc[c] = 0;
      bc[c] = 0;
    end
    coinc = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in = '0;
    run(3);
    rst_n = 1'b1;
    run(2);
    clr_counts();
  endtask

  initial begin
    int p1;
    for (int c = 0; c < N_CH; c++) begin
      sp[c] = '0;
      run_len[c] = 0;
      hage[c] = -1;
    end
    m_lvl = '0; m_dato = '0; m_dir = '0; m_busy = '0;
    clr_counts();
    bus.in = '0;
    bus.mode = 8'h00;
    bus.deb_len = 8'd1;
    bus.holdoff = 8'd0;
    #1;
    do_reset();

    // single rising edge, no debounce
    bus.in[0] = 1'b1;
    run(20);
    check("t1_pulses", 32'(pc[0]), 32'd1);
    check("t1_lvl", 32'(bus.lvl[0]), 32'd1);

    // glitch shorter than debounce window, then a qualifying one
    do_reset();
    bus.deb_len = 8'd4;
    bus.in[1] = 1'b1; run(3);
    bus.in[1] = 1'b0; run(8);
    check("t2_nopulse", 32'(pc[1]), 32'd0);
    check("t2_busy", 32'(bc[1]), 32'd3);
    check("t2_lvl", 32'(bus.lvl[1]), 32'd0);
    bus.in[1] = 1'b1; run(4);
    bus.in[1] = 1'b0; run(12);
    check("t2_pulse", 32'(pc[1]), 32'd1);

    // both edges with holdoff masking the early fall
    do_reset();
    bus.deb_len = 8'd1; bus.holdoff = 8'd5;
    bus.mode = 8'b11_10_00_00;
    bus.in[2] = 1'b1; run(2);
    bus.in[2] = 1'b0; run(10);
    check("t3_pulses", 32'(pc[2]), 32'd2);
    check("t3_lvl", 32'(bus.lvl[2]), 32'd0);

    // falling-only channel
    do_reset();
    bus.deb_len = 8'd2; bus.holdoff = 8'd0;
    bus.mode = 8'b01_11_11_11;
    bus.in[3] = 1'b1; run(6);
    check("t4_lvl_hi", 32'(bus.lvl[3]), 32'd1);
    bus.in[3] = 1'b0; run(6);
    check("t4_pulses", 32'(pc[3]), 32'd1);
    check("t4_lvl_lo", 32'(bus.lvl[3]), 32'd0);

    // disabled channel, then re-enabled with level already high
    do_reset();
    bus.deb_len = 8'd1;
    bus.mode = 8'b00_00_00_11;
    bus.in[0] = 1'b1; run(10);
    bus.mode = 8'h00; run(5);
    check("t5_pulses", 32'(pc[0]), 32'd0);
    check("t5_lvl", 32'(bus.lvl[0]), 32'd1);

    // coincident pulses, then reset during qualification
    do_reset();
    bus.mode = 8'h00; bus.deb_len = 8'd1; bus.holdoff = 8'd0;
    bus.in = 4'hF; run(6);
    check("t6_coinc", 32'(coinc), 32'd1);
    bus.deb_len = 8'd6;
    bus.in = 4'hD; run(4);
    check("t6_qual", 32'(bus.busy[1]), 32'd1);
    rst_n = 1'b0; bus.in = '0; run(1);
    check("t6_rst", {bus.dato, bus.edge_dir, bus.lvl, bus.busy}, 32'd0);
    rst_n = 1'b1;
    p1 = pc[1];
    run(10);
    check("t6_nopulse", 32'(pc[1] - p1), 32'd0);

    // randomised phase
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) begin
        bus.deb_len = CNT_W'($urandom_range(0, 5));
        bus.holdoff = CNT_W'($urandom_range(0, 6));
        bus.mode = 8'($urandom);
      end
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, 4) == 0) bus.in[c] = ~bus.in[c];
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
